beam_weight_sequencer: RTL and testbench

- Drives the four 5-bit beam weights (w_cos_1, w_sin_1, w_cos_2, w_sin_2) of the two-beam phase shifter.
- Holds a small programmable table of weight sets and steps through it as a beam sweep.
- Each entry is held for a programmable number of output-sample periods.
- Weight changes are aligned to the phase shifter's 1-in-8 output capture, so every captured sample uses one consistent weight set.

---
 rtl/beam_weight_sequencer.sv | 169 ++++++++++++++++
 tb/tb_beam_weight_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beam_weight_sequencer.sv
// Beam weight sequencer: sweeps a programmable weight-set table into the phase shifter,
// changing weights only on sample boundaries. Optional continuous sweep: PHASE_SWEEP_LOOP_EN.
module beam_weight_sequencer #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int W_W      = 5,
  parameter int DWELL_W  = 8,
  parameter int PRESCALE = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [4*W_W-1:0]   cfg_wdata,
  output logic               cfg_err,
  input  logic [ADDR_W-1:0]  num_steps,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               start,
  input  logic               abort,
  input  logic               loop_mode,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  step_idx,
  output logic               sample_stb,
  output logic [W_W-1:0]     w_cos_1,
  output logic [W_W-1:0]     w_sin_1,
  output logic [W_W-1:0]     w_cos_2,
  output logic [W_W-1:0]     w_sin_2,
  output logic [1:0]         dbg_state
);

  localparam int PS_W = $clog2(PRESCALE);
  localparam logic [ADDR_W-1:0] FIRST_IDX = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  // Control protocol: start and abort are single-clock request pulses with no ready;
  // start is honoured only in IDLE, abort only while busy (abort wins), and done is a
  // one-clock pulse issued on the edge that finishes (or wraps) a sweep.
  state_t              r_state;
  logic [PS_W-1:0]     r_ps_cnt;
  logic [4*W_W-1:0]    r_table [DEPTH];
  logic [4*W_W-1:0]    r_weights;
  logic [ADDR_W-1:0]   r_step_idx;
  logic [ADDR_W-1:0]   r_num_steps;
  logic [DWELL_W-1:0]  r_dwell_last;
  logic [DWELL_W-1:0]  r_dwell_cnt;
  logic                r_done;
  logic                r_cfg_err;
  logic                w_stb;
  logic                w_loop;
  logic [ADDR_W-1:0]   w_next_idx;

`ifdef PHASE_SWEEP_LOOP_EN
  logic r_loop;
  assign w_loop = r_loop;
`else
  logic w_unused_loop;
  assign w_unused_loop = loop_mode;
  assign w_loop        = 1'b0;
`endif

  // Counter shares reset with the phase shifter's prescaler, so both stay in phase.
  assign w_stb      = (r_ps_cnt == PS_W'(PRESCALE - 1));
  assign w_next_idx = r_step_idx + ADDR_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ps_cnt <= '0;
    end else if (w_stb) begin
      r_ps_cnt <= '0;
    end else begin
      r_ps_cnt <= r_ps_cnt + PS_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= '0;
      end
    end else if (cfg_we && (r_state == S_IDLE)) begin
      r_table[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_weights    <= '0;
      r_step_idx   <= '0;
      r_num_steps  <= '0;
      r_dwell_last <= '0;
      r_dwell_cnt  <= '0;
      r_done       <= 1'b0;
      r_cfg_err    <= 1'b0;
`ifdef PHASE_SWEEP_LOOP_EN
      r_loop       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (cfg_we && (r_state != S_IDLE)) begin
        r_cfg_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_state      <= S_ARM;
            r_num_steps  <= num_steps;
            // Dwell of 0 behaves like 1: store the last dwell count, not the length.
            r_dwell_last <= (dwell == '0) ? '0 : dwell - DWELL_W'(1);
`ifdef PHASE_SWEEP_LOOP_EN
            r_loop       <= loop_mode;
`endif
          end
        end
        S_ARM: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (w_stb) begin
            r_weights   <= r_table[FIRST_IDX];
            r_step_idx  <= FIRST_IDX;
            r_dwell_cnt <= '0;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (w_stb) begin
            if (r_dwell_cnt < r_dwell_last) begin
              r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
            end else if (r_step_idx < r_num_steps) begin
              r_step_idx  <= w_next_idx;
              r_weights   <= r_table[w_next_idx];
              r_dwell_cnt <= '0;
            end else begin
              r_done <= 1'b1;
              if (w_loop) begin
                r_weights   <= r_table[FIRST_IDX];
                r_step_idx  <= FIRST_IDX;
                r_dwell_cnt <= '0;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign cfg_err    = r_cfg_err;
  assign step_idx   = r_step_idx;
  assign sample_stb = w_stb;
  assign dbg_state  = r_state;
  assign w_cos_1    = r_weights[4*W_W-1 -: W_W];
  assign w_sin_1    = r_weights[3*W_W-1 -: W_W];
  assign w_cos_2    = r_weights[2*W_W-1 -: W_W];
  assign w_sin_2    = r_weights[W_W-1:0];

endmodule

// File: tb/tb_beam_weight_sequencer.sv
// Bench for beam_weight_sequencer: directed sweeps, expected weight-load and done events
// queued at stimulus time and popped by an output monitor. Clock k = period ending at edge k.
`timescale 1ns/1ps
module tb_beam_weight_sequencer;

  localparam int ADDR_W  = 4;
  localparam int W_W     = 5;
  localparam int DWELL_W = 8;
  localparam int EV_W    = 1 + 16 + ADDR_W + 4*W_W;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               cfg_we = 1'b0;
  logic [ADDR_W-1:0]  cfg_addr = '0;
  logic [4*W_W-1:0]   cfg_wdata = '0;
  logic               cfg_err;
  logic [ADDR_W-1:0]  num_steps = '0;
  logic [DWELL_W-1:0] dwell = '0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               loop_mode = 1'b0;
  logic               busy;
  logic               done;
  logic [ADDR_W-1:0]  step_idx;
  logic               sample_stb;
  logic [W_W-1:0]     w_cos_1, w_sin_1, w_cos_2, w_sin_2;
  logic [1:0]         dbg_state;
  logic [4*W_W-1:0]   cur_w;
  logic [4*W_W-1:0]   prev_w;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [EV_W-1:0] exp_q[$];

  beam_weight_sequencer dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_err(cfg_err), .num_steps(num_steps), .dwell(dwell),
    .start(start), .abort(abort), .loop_mode(loop_mode), .busy(busy), .done(done),
    .step_idx(step_idx), .sample_stb(sample_stb), .w_cos_1(w_cos_1), .w_sin_1(w_sin_1),
    .w_cos_2(w_cos_2), .w_sin_2(w_sin_2), .dbg_state(dbg_state)
  );

  assign cur_w = {w_cos_1, w_sin_1, w_cos_2, w_sin_2};

  // Clock and reset-relative cycle counter
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [4*W_W-1:0] pk(int a, int b, int c, int d);
    return {W_W'(a), W_W'(b), W_W'(c), W_W'(d)};
  endfunction

  function automatic logic [EV_W-1:0] ev(bit is_done, int edge_n, int idx, logic [4*W_W-1:0] w);
    return {is_done, 16'(edge_n), ADDR_W'(idx), w};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a weight change or a done pulse is one event
  task automatic check_event(logic [EV_W-1:0] act);
    logic [EV_W-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got done=%0d edge=%0d idx=%0d w=%h expected no event",
               act[EV_W-1], act[EV_W-2 -: 16], act[4*W_W +: ADDR_W], act[4*W_W-1:0]);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL event: got done=%0d edge=%0d idx=%0d w=%h expected done=%0d edge=%0d idx=%0d w=%h",
                 act[EV_W-1], act[EV_W-2 -: 16], act[4*W_W +: ADDR_W], act[4*W_W-1:0],
                 e[EV_W-1], e[EV_W-2 -: 16], e[4*W_W +: ADDR_W], e[4*W_W-1:0]);
      end
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (cur_w !== prev_w) check_event(ev(1'b0, cyc - 1, int'(step_idx), cur_w));
      if (done)             check_event(ev(1'b1, cyc - 1, int'(step_idx), cur_w));
    end
    prev_w = cur_w;
  end

  // Driver tasks
  task automatic at_clock(int k);
    while (cyc < k) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; cfg_we = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic write_entry(int k, int addr, logic [4*W_W-1:0] data);
    at_clock(k);
    cfg_we = 1'b1; cfg_addr = ADDR_W'(addr); cfg_wdata = data;
    at_clock(k + 1);
    cfg_we = 1'b0;
  endtask

  task automatic start_sweep(int k, int steps, int dw, bit lp);
    at_clock(k);
    num_steps = ADDR_W'(steps); dwell = DWELL_W'(dw); loop_mode = lp; start = 1'b1;
    at_clock(k + 1);
    start = 1'b0;
  endtask

  task automatic pulse_abort(int k);
    at_clock(k);
    abort = 1'b1;
    at_clock(k + 1);
    abort = 1'b0;
  endtask

  task automatic drain(int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clock);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending events expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    // Reset state and prescale strobe position
    do_reset();
    check("rst_weights", 32'(cur_w), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_step_idx", 32'(step_idx), 32'(0));
    check("rst_cfg_err", 32'(cfg_err), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(0));
    for (int k = 0; k < 16; k++) begin
      at_clock(k);
      check($sformatf("sample_stb_clk%0d", k), 32'(sample_stb), 32'((k == 7) || (k == 15)));
    end

    // Two-entry sweep, dwell 2
    do_reset();
    write_entry(0, 0, pk(1, 2, 3, 4));
    write_entry(1, 1, pk(5, 6, 7, 8));
    exp_q.push_back(ev(1'b0, 7, 0, pk(1, 2, 3, 4)));
    exp_q.push_back(ev(1'b0, 23, 1, pk(5, 6, 7, 8)));
    exp_q.push_back(ev(1'b1, 39, 1, pk(5, 6, 7, 8)));
    at_clock(3);
    check("busy_before_start", 32'(busy), 32'(0));
    start_sweep(3, 1, 2, 1'b0);
    check("busy_clk4", 32'(busy), 32'(1));
    drain(60);
    at_clock(41);
    check("busy_after_sweep", 32'(busy), 32'(0));
    check("final_step_idx", 32'(step_idx), 32'(1));
    check("final_weights", 32'(cur_w), 32'(pk(5, 6, 7, 8)));

    // Dwell 0 behaves as one sample period, single entry
    do_reset();
    write_entry(0, 0, pk(9, 10, 11, 12));
    exp_q.push_back(ev(1'b0, 7, 0, pk(9, 10, 11, 12)));
    exp_q.push_back(ev(1'b1, 15, 0, pk(9, 10, 11, 12)));
    start_sweep(1, 0, 0, 1'b0);
    drain(40);
    at_clock(17);
    check("dwell0_busy_after", 32'(busy), 32'(0));

    // Table write while busy is dropped and flagged
    do_reset();
    write_entry(0, 0, pk(1, 1, 1, 1));
    write_entry(1, 1, pk(2, 2, 2, 2));
    write_entry(2, 2, pk(4, 4, 4, 4));
    write_entry(3, 3, pk(3, 3, 3, 3));
    exp_q.push_back(ev(1'b0, 7, 0, pk(1, 1, 1, 1)));
    exp_q.push_back(ev(1'b0, 15, 1, pk(2, 2, 2, 2)));
    exp_q.push_back(ev(1'b1, 23, 1, pk(2, 2, 2, 2)));
    start_sweep(4, 1, 1, 1'b0);
    at_clock(10);
    cfg_we = 1'b1; cfg_addr = 4'd3; cfg_wdata = pk(31, 31, 31, 31);
    at_clock(11);
    cfg_we = 1'b0;
    check("cfg_err_set", 32'(cfg_err), 32'(1));
    drain(40);
    at_clock(25);
    exp_q.push_back(ev(1'b0, 31, 0, pk(1, 1, 1, 1)));
    exp_q.push_back(ev(1'b0, 39, 1, pk(2, 2, 2, 2)));
    exp_q.push_back(ev(1'b0, 47, 2, pk(4, 4, 4, 4)));
    exp_q.push_back(ev(1'b0, 55, 3, pk(3, 3, 3, 3)));
    exp_q.push_back(ev(1'b1, 63, 3, pk(3, 3, 3, 3)));
    start_sweep(25, 3, 1, 1'b0);
    drain(80);
    at_clock(65);
    check("cfg_err_sticky", 32'(cfg_err), 32'(1));
    do_reset();
    check("cfg_err_cleared", 32'(cfg_err), 32'(0));

    // Abort coinciding with a boundary edge, start+abort in IDLE, abort in ARM
    do_reset();
    write_entry(0, 0, pk(1, 2, 3, 4));
    write_entry(1, 1, pk(5, 6, 7, 8));
    exp_q.push_back(ev(1'b0, 7, 0, pk(1, 2, 3, 4)));
    start_sweep(2, 1, 1, 1'b0);
    pulse_abort(15);
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_step_idx", 32'(step_idx), 32'(0));
    check("abort_no_done", 32'(done), 32'(0));
    at_clock(20);
    start = 1'b1; abort = 1'b1;
    at_clock(21);
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", 32'(busy), 32'(0));
    start_sweep(26, 1, 1, 1'b0);
    check("arm_busy", 32'(busy), 32'(1));
    pulse_abort(28);
    check("arm_abort_busy", 32'(busy), 32'(0));
    at_clock(40);
    check("abort_weights_hold", 32'(cur_w), 32'(pk(1, 2, 3, 4)));
    drain(5);

    // Reset in the middle of a sweep clears state and table
    do_reset();
    write_entry(0, 0, pk(7, 7, 7, 7));
    exp_q.push_back(ev(1'b0, 7, 0, pk(7, 7, 7, 7)));
    start_sweep(1, 0, 3, 1'b0);
    at_clock(12);
    drain(5);
    do_reset();
    check("midrst_weights", 32'(cur_w), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_step_idx", 32'(step_idx), 32'(0));
    exp_q.push_back(ev(1'b1, 15, 0, pk(0, 0, 0, 0)));
    start_sweep(1, 0, 1, 1'b0);
    drain(40);
    at_clock(17);
    check("midrst_busy_after", 32'(busy), 32'(0));

    // Continuous sweep request
    do_reset();
    write_entry(0, 0, pk(1, 1, 1, 1));
    write_entry(1, 1, pk(2, 2, 2, 2));
    write_entry(2, 2, pk(3, 3, 3, 3));
`ifdef PHASE_SWEEP_LOOP_EN
    exp_q.push_back(ev(1'b0, 7, 0, pk(1, 1, 1, 1)));
    exp_q.push_back(ev(1'b0, 15, 1, pk(2, 2, 2, 2)));
    exp_q.push_back(ev(1'b0, 23, 2, pk(3, 3, 3, 3)));
    exp_q.push_back(ev(1'b0, 31, 0, pk(1, 1, 1, 1)));
    exp_q.push_back(ev(1'b1, 31, 0, pk(1, 1, 1, 1)));
    exp_q.push_back(ev(1'b0, 39, 1, pk(2, 2, 2, 2)));
    exp_q.push_back(ev(1'b0, 47, 2, pk(3, 3, 3, 3)));
    exp_q.push_back(ev(1'b0, 55, 0, pk(1, 1, 1, 1)));
    exp_q.push_back(ev(1'b1, 55, 0, pk(1, 1, 1, 1)));
    start_sweep(3, 2, 1, 1'b1);
    at_clock(50);
    check("loop_busy_held", 32'(busy), 32'(1));
    pulse_abort(60);
    check("loop_abort_busy", 32'(busy), 32'(0));
    check("loop_abort_step_idx", 32'(step_idx), 32'(0));
    drain(5);
`else
    exp_q.push_back(ev(1'b0, 7, 0, pk(1, 1, 1, 1)));
    exp_q.push_back(ev(1'b0, 15, 1, pk(2, 2, 2, 2)));
    exp_q.push_back(ev(1'b0, 23, 2, pk(3, 3, 3, 3)));
    exp_q.push_back(ev(1'b1, 31, 2, pk(3, 3, 3, 3)));
    start_sweep(3, 2, 1, 1'b1);
    drain(60);
    at_clock(33);
    check("noloop_busy_after", 32'(busy), 32'(0));
    at_clock(48);
    check("noloop_stays_idle", 32'(busy), 32'(0));
`endif

    drain(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
